tsip_deframer: RTL

//  Byte-level TSIP deframer in the Thunderbolt GPS receive path. Sits between the

---
 rtl/tsip_pkg.sv | 23 ++
 rtl/tsip_deframer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tsip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tsip_pkg
//  Description : Shared TSIP framing constants and the deframer state
//                encoding. The TSIP TX framer imports the same definitions.
//  Revision    : 1.0  initial release
// ============================================================================
package tsip_pkg;

    // Framing bytes.
    localparam logic [7:0] c_dle = 8'h10;
    localparam logic [7:0] c_etx = 8'h03;

    // Deframer states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ID       = 2'd1,
        ST_DATA     = 2'd2,
        ST_DLE_SEEN = 2'd3
    } tsip_state_t;

endpackage : tsip_pkg
`default_nettype wire

// File: rtl/tsip_deframer.sv
`default_nettype none
// ============================================================================
//  Module      : tsip_deframer
//  Description : Byte-level TSIP deframer. Hunts for DLE-framed packets,
//                removes DLE stuffing, latches packet ID and payload, and
//                presents each complete good packet with a one-cycle strobe.
//  Config      : TSIP_ID_FILTER_EN - when defined, only frames whose ID equals
//                ACCEPT_ID are delivered (and only they can flag overflow).
//  Ports       : i_clk       system clock
//                i_rst       asynchronous active-high reset
//                i_rx_byte   received byte, qualified by i_rx_dv
//                i_rx_dv     one-cycle byte strobe
//                o_pkt_id    ID of the last good packet
//                o_pkt_data  payload, byte k at [8k+7:8k], unused bytes 0
//                o_pkt_len   payload byte count of the last good packet
//                o_pkt_dv    one-cycle strobe: new good packet on outputs
//                o_pkt_err   one-cycle strobe: framing error or overflow
//  Revision    : 1.0  initial release
// ============================================================================
module tsip_deframer
    import tsip_pkg::*;
#(
    parameter int         MAX_BYTES = 32,
    parameter logic [7:0] ACCEPT_ID = 8'h8F,
    localparam int        LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_rst,
    input  wire logic [7:0]             i_rx_byte,
    input  wire logic                   i_rx_dv,
    output logic      [7:0]             o_pkt_id,
    output logic      [MAX_BYTES*8-1:0] o_pkt_data,
    output logic      [LEN_W-1:0]       o_pkt_len,
    output logic                        o_pkt_dv,
    output logic                        o_pkt_err
);

`ifdef TSIP_ID_FILTER_EN
    localparam bit c_filter_en = 1'b1;
`else
    localparam bit c_filter_en = 1'b0;
`endif

    tsip_state_t      r_state;
    logic [7:0]       r_id;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic [7:0]       r_buf [MAX_BYTES];

    logic w_is_dle;
    logic w_is_etx;
    logic w_start;
    logic w_store;
    logic w_resync;
    logic w_eof;
    logic w_room;
    logic w_id_ok;

    assign w_is_dle = (i_rx_byte == c_dle);
    assign w_is_etx = (i_rx_byte == c_etx);

    // A new frame begins either after a fresh DLE (ID state) or when a DLE
    // in the payload is followed by an ordinary byte: that byte is taken as
    // the ID of a new frame so we resynchronise without losing it.
    assign w_start  = i_rx_dv && !w_is_dle && !w_is_etx &&
                      ((r_state == ST_ID) || (r_state == ST_DLE_SEEN));
    assign w_resync = i_rx_dv && (r_state == ST_DLE_SEEN) && !w_is_dle && !w_is_etx;
    assign w_eof    = i_rx_dv && (r_state == ST_DLE_SEEN) && w_is_etx;

    // Payload bytes: plain bytes in DATA, or the second DLE of a stuffed pair
    // (whose value is DLE itself, so the raw input byte is always stored).
    assign w_store  = i_rx_dv &&
                      (((r_state == ST_DATA) && !w_is_dle) ||
                       ((r_state == ST_DLE_SEEN) && w_is_dle));

    assign w_room   = (r_len < LEN_W'(MAX_BYTES));
    assign w_id_ok  = !c_filter_en || (r_id == ACCEPT_ID);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_id       <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            for (int k = 0; k < MAX_BYTES; k++) r_buf[k] <= '0;
            o_pkt_id   <= '0;
            o_pkt_data <= '0;
            o_pkt_len  <= '0;
            o_pkt_dv   <= 1'b0;
            o_pkt_err  <= 1'b0;
        end else begin
            o_pkt_dv  <= 1'b0;
            o_pkt_err <= 1'b0;

            if (i_rx_dv) begin
                case (r_state)
                    ST_IDLE:     if (w_is_dle) r_state <= ST_ID;
                    ST_ID:       r_state <= (w_is_dle || w_is_etx) ? ST_IDLE : ST_DATA;
                    ST_DATA:     if (w_is_dle) r_state <= ST_DLE_SEEN;
                    ST_DLE_SEEN: r_state <= w_is_etx ? ST_IDLE : ST_DATA;
                    default:     r_state <= ST_IDLE;
                endcase
            end

            if (w_start) begin
                r_id  <= i_rx_byte;
                r_len <= '0;
                r_ovf <= 1'b0;
                for (int k = 0; k < MAX_BYTES; k++) r_buf[k] <= '0;
            end else if (w_store) begin
                if (w_room) begin
                    for (int k = 0; k < MAX_BYTES; k++) begin
                        if (r_len == LEN_W'(k)) r_buf[k] <= i_rx_byte;
                    end
                    r_len <= r_len + 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end

            if (w_resync) o_pkt_err <= 1'b1;

            // Frames rejected by the ID filter end silently, overflow or not.
            if (w_eof && w_id_ok) begin
                if (r_ovf) begin
                    o_pkt_err <= 1'b1;
                end else begin
                    o_pkt_id  <= r_id;
                    o_pkt_len <= r_len;
                    for (int k = 0; k < MAX_BYTES; k++) o_pkt_data[8*k +: 8] <= r_buf[k];
                    o_pkt_dv  <= 1'b1;
                end
            end
        end
    end

endmodule : tsip_deframer
`default_nettype wire
